// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        WAIT  = 3'd4,
        STORE = 3'd5
    } seq_state_t;

endpackage

// File: rtl/d_ff_async_en.sv
// Generic enabled register with asynchronous active-low reset to a parameterised value.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; q holds whenever en is low.
module d_ff_async_en #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on enabled cycles, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_timeout_cnt.sv
// Up-counter of WAIT cycles with clear and enable; tc flags the LIMIT-th counted cycle.
// Latency: tc is combinational from the count register, count updates 1 cycle after en.
// Backpressure: none; clear has priority over enable.
module seq_timeout_cnt #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins; otherwise advance by one on enabled cycles.
    always_comb begin
        cnt_d = clr ? '0 : cnt_q + 1'b1;
    end

    d_ff_async_en #(.WIDTH(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (clr | en),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // Terminal count: the current cycle is the LIMIT-th one counted.
    always_comb begin
        tc = (cnt_q == CW'(LIMIT - 1));
    end

endmodule

// File: rtl/alu_sequencer.sv
// Pops one {op,data1,data0} word, drives a multi-cycle ALU, writes the result (or an all-ones error word) out.
// Latency: IDLE->FETCH->LOAD->EXEC->WAIT(ALU latency)->STORE; bad opcodes skip straight from LOAD to STORE.
// Backpressure: STORE stalls while full_out is high with the result held; FIFO_IN is only read when not empty.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int OPERATION_SIZE = 2,
    parameter int DATA_WIDTH     = 12,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 seq_en,
    input  logic                                 empty_in,
    input  logic [OPERATION_SIZE+2*DATA_WIDTH-1:0] fifo_in_data,
    output logic                                 r_en_in,
    output logic [OPERATION_SIZE-1:0]            alu_op,
    output logic [DATA_WIDTH-1:0]                alu_a,
    output logic [DATA_WIDTH-1:0]                alu_b,
    output logic                                 alu_start,
    input  logic                                 alu_done,
    input  logic [FIFO_OUT_WIDTH-1:0]            alu_result,
    input  logic                                 full_out,
    output logic                                 w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0]            fifo_out_data,
    output logic                                 busy,
    input  logic                                 err_clr,
    output logic                                 err_flag,
    output logic [7:0]                           ops_done
);

    localparam logic [FIFO_OUT_WIDTH-1:0] ERR_WORD = {FIFO_OUT_WIDTH{1'b1}};

    seq_state_t state_q;
    seq_state_t state_d;

    // Fields of the incoming word: {op, data1, data0}.
    logic [OPERATION_SIZE-1:0] in_op;
    logic [DATA_WIDTH-1:0]     in_data0;
    logic [DATA_WIDTH-1:0]     in_data1;
    logic                      op_valid;

    logic                      ld_ops;
    logic                      res_ld;
    logic [FIFO_OUT_WIDTH-1:0] res_d;
    logic                      err_set;
    logic                      cnt_clr;
    logic                      cnt_en;
    logic                      timeout_tc;

    // Split the FIFO_IN word and decide whether the opcode is one the ALU supports.
    always_comb begin
        in_data0 = fifo_in_data[DATA_WIDTH-1:0];
        in_data1 = fifo_in_data[2*DATA_WIDTH-1:DATA_WIDTH];
        in_op    = fifo_in_data[OPERATION_SIZE+2*DATA_WIDTH-1:2*DATA_WIDTH];
        op_valid = (in_op == OPERATION_SIZE'(OP_ADD)) || (in_op == OPERATION_SIZE'(OP_MUL));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; seq_en is only consulted in IDLE so a started op always finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (seq_en && !empty_in) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = op_valid ? EXEC : STORE;
            EXEC:    state_d = WAIT;
            WAIT:    if (alu_done || timeout_tc) state_d = STORE;
            STORE:   if (!full_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state strobes and register load controls; alu_done is only honoured in WAIT.
    always_comb begin
        r_en_in   = 1'b0;
        alu_start = 1'b0;
        w_en_out  = 1'b0;
        busy      = (state_q != IDLE);
        ld_ops    = 1'b0;
        res_ld    = 1'b0;
        res_d     = ERR_WORD;
        err_set   = 1'b0;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;
        case (state_q)
            FETCH: r_en_in = 1'b1;
            LOAD: begin
                ld_ops  = 1'b1;
                res_ld  = !op_valid;
                err_set = !op_valid;
            end
            EXEC: alu_start = 1'b1;
            WAIT: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                if (alu_done) begin
                    res_ld = 1'b1;
                    res_d  = alu_result;
                end else if (timeout_tc) begin
                    res_ld  = 1'b1;
                    err_set = 1'b1;
                end
            end
            STORE: w_en_out = !full_out;
            default: ;
        endcase
    end

    d_ff_async_en #(.WIDTH(OPERATION_SIZE)) u_op_reg (
        .clk (clk), .rst_n (rst_n), .en (ld_ops), .d (in_op), .q (alu_op)
    );

    d_ff_async_en #(.WIDTH(DATA_WIDTH)) u_a_reg (
        .clk (clk), .rst_n (rst_n), .en (ld_ops), .d (in_data0), .q (alu_a)
    );

    d_ff_async_en #(.WIDTH(DATA_WIDTH)) u_b_reg (
        .clk (clk), .rst_n (rst_n), .en (ld_ops), .d (in_data1), .q (alu_b)
    );

    d_ff_async_en #(.WIDTH(FIFO_OUT_WIDTH)) u_res_reg (
        .clk (clk), .rst_n (rst_n), .en (res_ld), .d (res_d), .q (fifo_out_data)
    );

    // Sticky error: a set in the same cycle as a clear leaves the flag set.
    d_ff_async_en #(.WIDTH(1)) u_err_reg (
        .clk (clk), .rst_n (rst_n), .en (err_set | err_clr), .d (err_set), .q (err_flag)
    );

    // Completed-op counter, wraps naturally at 8 bits.
    d_ff_async_en #(.WIDTH(8)) u_ops_reg (
        .clk (clk), .rst_n (rst_n), .en (w_en_out), .d (ops_done + 8'd1), .q (ops_done)
    );

    seq_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (timeout_tc)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a FIFO_IN queue model, a fixed-latency ALU model and a write monitor.
// Latency: checks are exact cycle-by-cycle against the state sequence.
// Backpressure: full_out is driven directly by the stimulus.
module tb_alu_sequencer;

    localparam int OPW = 2;
    localparam int DW  = 12;
    localparam int RW  = 25;
    localparam logic [RW-1:0] ERR = 25'h1FFFFFF;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  seq_en = 1'b0;
    logic                  empty_in = 1'b1;
    logic [OPW+2*DW-1:0]   fifo_in_data = '0;
    logic                  r_en_in;
    logic [OPW-1:0]        alu_op;
    logic [DW-1:0]         alu_a;
    logic [DW-1:0]         alu_b;
    logic                  alu_start;
    logic                  alu_done = 1'b0;
    logic [RW-1:0]         alu_result = '0;
    logic                  full_out = 1'b0;
    logic                  w_en_out;
    logic [RW-1:0]         fifo_out_data;
    logic                  busy;
    logic                  err_clr = 1'b0;
    logic                  err_flag;
    logic [7:0]            ops_done;

    int tests = 0;
    int fails = 0;

    logic [OPW+2*DW-1:0] inq[$];
    int            alu_lat = 0;
    int            alu_cnt = 0;
    int            alu_starts = 0;
    int            wr_count = 0;
    logic [RW-1:0] last_wr = '0;

    alu_sequencer #(
        .OPERATION_SIZE (OPW),
        .DATA_WIDTH     (DW),
        .FIFO_OUT_WIDTH (RW),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seq_en        (seq_en),
        .empty_in      (empty_in),
        .fifo_in_data  (fifo_in_data),
        .r_en_in       (r_en_in),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_start     (alu_start),
        .alu_done      (alu_done),
        .alu_result    (alu_result),
        .full_out      (full_out),
        .w_en_out      (w_en_out),
        .fifo_out_data (fifo_out_data),
        .busy          (busy),
        .err_clr       (err_clr),
        .err_flag      (err_flag),
        .ops_done      (ops_done)
    );

    always #5 clk = ~clk;

    // FIFO_IN model and FIFO_OUT write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (w_en_out) begin
            wr_count = wr_count + 1;
            last_wr  = fifo_out_data;
        end
        if (r_en_in && inq.size() > 0) begin
            fifo_in_data = inq.pop_front();
        end
        empty_in = (inq.size() == 0);
    end

    // ALU model: alu_done pulses alu_lat cycles after the start cycle; alu_lat == 0 means never.
    always @(negedge clk) begin
        alu_done = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt = alu_cnt - 1;
            if (alu_cnt == 0) alu_done = 1'b1;
        end
        if (alu_start) begin
            alu_starts = alu_starts + 1;
            if (alu_lat > 0) alu_cnt = alu_lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int saw;
        int ok;
        int wr0;
        int st0;

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {r_en_in, alu_start, w_en_out}, 0);
        chk("rst_operands", {alu_op, alu_a, alu_b}, 0);
        chk("rst_fifo_out_data", fifo_out_data, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_ops_done", ops_done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ADD, 3-cycle ALU, result 8.
        alu_lat     = 3;
        alu_result  = 25'h0000008;
        seq_en      = 1'b1;
        inq.push_back({2'b01, 12'h003, 12'h005});
        tick();
        chk("add_fetch_ren", r_en_in, 1);
        tick();
        chk("add_load_ren", {busy, r_en_in}, 2'b10);
        tick();
        chk("add_exec_start", alu_start, 1);
        chk("add_exec_operands", {alu_op, alu_a, alu_b}, {2'b01, 12'h005, 12'h003});
        tick();
        chk("add_wait_start_low", alu_start, 0);
        tick();
        tick();
        chk("add_wait_no_write", w_en_out, 0);
        tick();
        chk("add_store_wen", w_en_out, 1);
        chk("add_store_data", fifo_out_data, 25'h0000008);
        chk("add_operands_held", {alu_op, alu_a, alu_b}, {2'b01, 12'h005, 12'h003});
        tick();
        chk("add_ops_done", ops_done, 1);
        chk("add_idle", busy, 0);
        chk("add_writes", wr_count, 1);
        chk("add_starts", alu_starts, 1);

        // Invalid opcode with err_clr held: set wins in LOAD, clear takes effect next cycle.
        err_clr = 1'b1;
        inq.push_back({2'b11, 12'h0AA, 12'h055});
        tick();
        tick();
        tick();
        chk("bad_store_wen", w_en_out, 1);
        chk("bad_store_data", fifo_out_data, ERR);
        chk("bad_err_set_wins", err_flag, 1);
        tick();
        chk("bad_err_cleared", err_flag, 0);
        chk("bad_ops_done", ops_done, 2);
        chk("bad_no_start", alu_starts, 1);
        err_clr = 1'b0;

        // MUL with an ALU that never answers: exactly 64 WAIT cycles then the error word.
        alu_lat = 0;
        inq.push_back({2'b10, 12'h002, 12'h007});
        tick();
        tick();
        tick();
        chk("tmo_exec_op", {alu_start, alu_op}, {1'b1, 2'b10});
        saw = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (w_en_out) saw = 1;
        end
        chk("tmo_no_early_write", saw, 0);
        chk("tmo_still_busy", busy, 1);
        tick();
        chk("tmo_store_wen", w_en_out, 1);
        chk("tmo_store_data", fifo_out_data, ERR);
        chk("tmo_err_flag", err_flag, 1);
        tick();
        chk("tmo_ops_done", ops_done, 3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_err_cleared", err_flag, 0);

        // Backpressure: full_out high for 10 cycles in STORE.
        alu_lat    = 2;
        alu_result = 25'h0ABCDEF;
        full_out   = 1'b1;
        wr0        = wr_count;
        inq.push_back({2'b01, 12'h111, 12'h222});
        for (int i = 0; i < 6; i++) tick();
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            if (w_en_out) saw = 1;
            tick();
        end
        chk("bp_no_write_while_full", saw, 0);
        chk("bp_held_busy", busy, 1);
        full_out = 1'b0;
        #1;
        chk("bp_wen_after_release", w_en_out, 1);
        chk("bp_data_unchanged", fifo_out_data, 25'h0ABCDEF);
        tick();
        chk("bp_single_write", wr_count - wr0, 1);
        chk("bp_ops_done", ops_done, 4);

        // seq_en dropped during WAIT with two ops queued.
        alu_lat    = 4;
        alu_result = 25'h0000010;
        wr0        = wr_count;
        st0        = alu_starts;
        inq.push_back({2'b01, 12'h00A, 12'h006});
        inq.push_back({2'b01, 12'h00A, 12'h006});
        tick();
        tick();
        tick();
        tick();
        seq_en = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            tick();
            if (wr_count > wr0) ok = 1;
        end
        chk("seq_first_completes", ok, 1);
        chk("seq_first_data", last_wr, 25'h0000010);
        for (int i = 0; i < 5; i++) tick();
        chk("seq_idle", busy, 0);
        chk("seq_second_not_fetched", inq.size(), 1);
        chk("seq_one_start", alu_starts - st0, 1);
        chk("seq_ops_done", ops_done, 5);

        // Reset pulsed during WAIT.
        alu_lat = 0;
        seq_en  = 1'b1;
        wr0     = wr_count;
        tick();
        tick();
        tick();
        tick();
        chk("rstw_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_strobes", {r_en_in, alu_start, w_en_out}, 0);
        chk("rstw_operands", {alu_op, alu_a, alu_b}, 0);
        chk("rstw_fifo_out_data", fifo_out_data, 0);
        chk("rstw_ops_done", ops_done, 0);
        tick();
        tick();
        rst_n  = 1'b1;
        seq_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rstw_no_write", wr_count - wr0, 0);
        chk("rstw_ops_after", ops_done, 0);
        chk("rstw_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter OPERATION_SIZE, default 2, opcode width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, width of each operand.
REQ-003 SHALL have parameter FIFO_OUT_WIDTH, default 25, result word width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum cycles in WAIT before abort.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-006 Ports (name  direction  width  meaning):
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  async active-low reset
 seq_en  in  1  sequencer enable, from start_bit
 empty_in  in  1  FIFO_IN empty
 fifo_in_data  in  OPERATION_SIZE+2*DATA_WIDTH  {op, data1, data0}, valid the cycle after r_en_in
 r_en_in  out  1  FIFO_IN read strobe
 alu_op  out  OPERATION_SIZE  opcode to ALU
 alu_a, alu_b  out  DATA_WIDTH each  operands data0, data1
 alu_start  out  1  one-cycle ALU start pulse
 alu_done  in  1  ALU completion pulse
 alu_result  in  FIFO_OUT_WIDTH  ALU result, valid with alu_done
 full_out  in  1  FIFO_OUT full
 w_en_out  out  1  FIFO_OUT write strobe
 fifo_out_data  out  FIFO_OUT_WIDTH  word written to FIFO_OUT
 busy  out  1  high in any state other than IDLE
 err_clr  in  1  clears err_flag
 err_flag  out  1  sticky error flag
 ops_done  out  8  completed-operation counter

Function
REQ-007 FSM states SHALL be IDLE, FETCH, LOAD, EXEC, WAIT, STORE.
REQ-008 IDLE->FETCH when seq_en=1 and empty_in=0; otherwise remain in IDLE.
REQ-009 FETCH SHALL assert r_en_in for exactly one cycle, then go to LOAD.
REQ-010 LOAD SHALL register fifo_in_data into op/operand registers; valid op (01 add, 10 mul) -> EXEC; other op -> STORE with error word.
REQ-011 EXEC SHALL pulse alu_start for one cycle with alu_op/alu_a/alu_b stable, then go to WAIT.
REQ-012 alu_op/alu_a/alu_b SHALL be held stable from EXEC until STORE exits.
REQ-013 WAIT SHALL capture alu_result on alu_done=1 and go to STORE; alu_done outside WAIT SHALL be ignored.
REQ-014 WAIT SHALL count cycles; at TIMEOUT_CYCLES without alu_done -> STORE with error word.
REQ-015 Error word SHALL be all ones ({FIFO_OUT_WIDTH{1'b1}}); error cases SHALL set err_flag.
REQ-016 STORE SHALL assert w_en_out with fifo_out_data only while full_out=0; while full_out=1 hold in STORE, w_en_out=0, data held.
REQ-017 On write, ops_done SHALL increment by 1 (wraps 255->0, error words included) and FSM returns to IDLE.
REQ-018 seq_en deassertion mid-operation SHALL NOT abort; the current op completes through STORE, then IDLE.
REQ-019 err_clr SHALL clear err_flag next cycle; simultaneous set and clear -> set wins.
REQ-020 Minimum latency IDLE->w_en_out SHALL be 5 cycles plus ALU latency; no back-to-back fetch without IDLE.

Reset
REQ-021 On rst_n=0, asynchronously: state=IDLE, all strobes 0, alu_op/alu_a/alu_b=0, fifo_out_data=0, timeout counter=0, err_flag=0, ops_done=0, busy=0.
REQ-022 Reset mid-operation SHALL discard the in-flight op with no FIFO_OUT write.

Structure
REQ-023 Opcode constants (OP_ADD=2'b01, OP_MUL=2'b10) and state encoding SHALL live in shared package alu_pkg.
REQ-024 Timeout counter SHALL be sub-module seq_timeout_cnt (load/clear, enable, terminal-count output); registers SHALL use d_ff_async_en.

Verification
REQ-025 op=01, data0=12'h005, data1=12'h003, ALU model 3-cycle latency returns 25'h8 -> one alu_start, w_en_out with 25'h0000008, ops_done=1.
REQ-026 op=11 queued -> no alu_start, w_en_out with 25'h1FFFFFF, err_flag=1; err_clr -> err_flag=0.
REQ-027 op=10, ALU never asserts alu_done -> 64 cycles in WAIT, error word written, err_flag=1.
REQ-028 full_out=1 for 10 cycles at STORE -> w_en_out=0 throughout, single write after full_out falls, data unchanged.
REQ-029 seq_en dropped during WAIT, 2 ops queued -> first op completes, second not fetched, busy=0.
REQ-030 rst_n pulsed low during WAIT -> all outputs 0 immediately, no FIFO_OUT write, ops_done=0.
